router_src_ctrl: RTL
====================

Name: router_src_ctrl

Overview:
- Parametrised successor to the fixed 1x3 router input side.
- Accepts byte-serial packets (header, payload, parity) from the source driver and steers each accepted byte to one of NUM_CH destination FIFOs.
- Applies busy back-pressure per destination FIFO.
- Checks parity, payload length and destination address, and reports a coded error per packet.

Parameters:
- DATA_W, 8, width of data_in/wr_data and of every packet byte.
- NUM_CH, 3, number of destination channels (2..16).
- ADDR_W, $clog2(NUM_CH), header address field width (derived; not overridden).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- data_in  in  DATA_W  packet byte from source.
- pkt_valid  in  1  high during header and payload bytes; the parity byte is on the first cycle it is low.
- fifo_full  in  NUM_CH  per-channel full; must assert with ≥1 entry of headroom.
- busy  out  1  source must hold data_in/pkt_valid stable while high.
- wr_en  out  NUM_CH  one-hot write strobe to the destination FIFO.
- wr_data  out  DATA_W  byte to write.
- error  out  1  packet error flag.
- err_code  out  2  0 none, 1 parity, 2 length, 3 bad address.

Behaviour:
- Header decode:
  - addr = data_in[ADDR_W-1:0].
  - len = data_in[DATA_W-1:ADDR_W] = number of payload bytes; 0 is legal.
- A byte is accepted on a rising edge when it is presented and busy=0 in that cycle.
- busy is combinational from state and fifo_full.
- Accepted header and payload bytes appear on wr_data with wr_en[addr]=1 exactly one cycle after acceptance.
- The parity byte is never written.
- Running parity: XOR of header and all payload bytes, compared against the parity byte.
- Reset (reset=0, async):
  - state IDLE; busy=0, wr_en=0, wr_data=0, error=0, err_code=0; counters and parity cleared.
  - A packet in flight is abandoned; no partial write completes after reset.
- IDLE:
  - busy=0.
  - pkt_valid=1 with addr≥NUM_CH -> DROP; set error=1, err_code=3; nothing written.
  - pkt_valid=1 with fifo_full[addr]=1 -> HDR_WAIT (header not accepted).
  - Otherwise accept header, latch addr/len, init parity=header, count=0 -> LOAD_DATA.
- HDR_WAIT:
  - busy=1.
  - When fifo_full[addr]=0, accept header next cycle via the IDLE rules.
- LOAD_DATA:
  - busy=fifo_full[addr].
  - pkt_valid=1 and busy=0: accept payload, count+1, parity^=byte.
  - pkt_valid=0: current byte is the parity byte; accept it -> CHECK.
- CHECK (1 cycle):
  - busy=1.
  - Compute the result; go to IDLE.
  - If count≠len: error=1, err_code=2 (length has priority over parity).
  - Else if parity mismatch: error=1, err_code=1.
  - Else error=0, err_code=0.
- DROP:
  - busy=0; consume bytes until pkt_valid=0 (that byte is the discarded parity byte) -> IDLE.
- error/err_code hold their value until the next header is accepted, or a bad-address header is seen; they are then cleared or reloaded.
- Payload overrun: more than len bytes with pkt_valid=1.
  - Excess bytes are still written (count saturates at 2^(DATA_W-ADDR_W)-1).
  - Flagged as a length error at CHECK.
- fifo_full changes mid-payload: busy follows it combinationally in the same cycle.
- Back-to-back packets:
  - A new header may be presented the cycle after CHECK.
  - One idle cycle minimum between a parity byte and the next header.
- Only the latched addr's fifo_full is observed after header acceptance.
- Implementation: single FSM, length counter, parity register, output register stage, about 200 RTL lines.

Test Plan:
- Clean packet, NUM_CH=3: header 8'h16 (addr 2, len 5), payload 01..05, parity 8'h16^01^02^03^04^05=8'h17 -> wr_en=3'b100 for 6 consecutive cycles, starting 1 cycle after header; wr_data 16,01..05; error=0, err_code=0.
- Parity error: same packet, parity 8'h00 -> 6 writes; CHECK cycle sets error=1, err_code=1, held until the next header.
- Back-pressure: fifo_full[2]=1 for 3 cycles mid-payload after byte 2 -> busy=1 for exactly those 3 cycles; no wr_en during the stall; remaining bytes written in order; no byte lost or duplicated.
- Bad address: header 8'h0B (addr 3) with NUM_CH=3 -> error=1, err_code=3, wr_en never asserted; the next packet to addr 0 is accepted normally and clears error.
- Length error: header len=4, pkt_valid falls after 2 payload bytes -> 3 writes, then err_code=2; repeat with 6 payload bytes -> 7 writes, err_code=2.
- Reset mid-packet: reset low after byte 3 of 5 -> all outputs 0 asynchronously; after release, a fresh packet to addr 1 completes with error=0.
- Regression at NUM_CH=4, DATA_W=16: random packets to all channels with random fifo_full -> scoreboard matches per-channel byte streams.

Source files
------------

// File: rtl/router_src_ctrl.sv
// Input side of a 1xNUM_CH packet router: steers header/payload bytes to one
// destination FIFO, applies per-channel back-pressure and checks each packet.
module router_src_ctrl #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pkt_valid,
    input  logic [NUM_CH-1:0] fifo_full,
    output logic              busy,
    output logic [NUM_CH-1:0] wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              error,
    output logic [1:0]        err_code
);

    localparam int ADDR_W = $clog2(NUM_CH);
    localparam int LEN_W  = DATA_W - ADDR_W;
    localparam logic [ADDR_W:0] NUM_CH_W = (ADDR_W + 1)'(NUM_CH);

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_PARITY = 2'd1;
    localparam logic [1:0] ERR_LENGTH = 2'd2;
    localparam logic [1:0] ERR_ADDR   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_WAIT,
        S_LOAD_DATA,
        S_CHECK,
        S_DROP
    } state_t;

    state_t              state_q;
    logic [NUM_CH-1:0]   sel_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    cnt_q;
    logic [LEN_W-1:0]    cnt_d;
    logic [DATA_W-1:0]   par_q;
    logic [NUM_CH-1:0]   wr_en_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic                error_q;
    logic [1:0]          err_code_q;

    logic [ADDR_W-1:0]   hdr_addr;
    logic [LEN_W-1:0]    hdr_len;
    logic [NUM_CH-1:0]   hdr_sel;
    logic                hdr_bad;
    logic                hdr_full;
    logic                cur_full;

    function automatic logic [NUM_CH-1:0] onehot(input logic [ADDR_W-1:0] a);
        logic [NUM_CH-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (a == ADDR_W'(i)) r[i] = 1'b1;
        end
        return r;
    endfunction

    assign hdr_addr = data_in[ADDR_W-1:0];
    assign hdr_len  = data_in[DATA_W-1:ADDR_W];
    assign hdr_sel  = onehot(hdr_addr);
    assign hdr_bad  = ({1'b0, hdr_addr} >= NUM_CH_W);
    assign hdr_full = |(fifo_full & hdr_sel);
    // After header acceptance only the latched channel's full flag matters.
    assign cur_full = |(fifo_full & sel_q);
    assign cnt_d    = (cnt_q == {LEN_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        busy = 1'b0;
        unique case (state_q)
            S_IDLE:      busy = 1'b0;
            S_HDR_WAIT:  busy = 1'b1;
            S_LOAD_DATA: busy = cur_full;
            S_CHECK:     busy = 1'b1;
            S_DROP:      busy = 1'b0;
            default:     busy = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            sel_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            par_q      <= '0;
            wr_en_q    <= '0;
            wr_data_q  <= '0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            wr_en_q <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (pkt_valid) begin
                        if (hdr_bad) begin
                            error_q    <= 1'b1;
                            err_code_q <= ERR_ADDR;
                            state_q    <= S_DROP;
                        end else if (hdr_full) begin
                            sel_q   <= hdr_sel;
                            state_q <= S_HDR_WAIT;
                        end else begin
                            sel_q      <= hdr_sel;
                            len_q      <= hdr_len;
                            cnt_q      <= '0;
                            par_q      <= data_in;
                            wr_en_q    <= hdr_sel;
                            wr_data_q  <= data_in;
                            error_q    <= 1'b0;
                            err_code_q <= ERR_NONE;
                            state_q    <= S_LOAD_DATA;
                        end
                    end
                end
                S_HDR_WAIT: begin
                    // Header is re-evaluated from IDLE once the channel frees up.
                    if (!cur_full) state_q <= S_IDLE;
                end
                S_LOAD_DATA: begin
                    if (!cur_full) begin
                        par_q <= par_q ^ data_in;
                        if (pkt_valid) begin
                            wr_en_q   <= sel_q;
                            wr_data_q <= data_in;
                            cnt_q     <= cnt_d;
                        end else begin
                            state_q <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    // Parity register now holds header^payload^parity; zero means match.
                    if (cnt_q != len_q) begin
                        error_q    <= 1'b1;
                        err_code_q <= ERR_LENGTH;
                    end else if (par_q != '0) begin
                        error_q    <= 1'b1;
                        err_code_q <= ERR_PARITY;
                    end else begin
                        error_q    <= 1'b0;
                        err_code_q <= ERR_NONE;
                    end
                    state_q <= S_IDLE;
                end
                S_DROP: begin
                    if (!pkt_valid) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_data  = wr_data_q;
    assign error    = error_q;
    assign err_code = err_code_q;

endmodule
